// File: rtl/f2x_pkg.sv
// Shared IEEE-754 single field layout, classification codes and flag positions
// for the float-to-fixed pipeline.
package f2x_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int SIG_W  = MAN_W + 1;
  localparam int BIAS   = 127;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  localparam int FLAG_NAN = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } f2x_cls_e;
endpackage

// File: rtl/f2x_round_sat.sv
// Final stage logic: round (F2X_ROUND_EN) or truncate, negate, saturate, flag.
// Purely combinational; registered by the parent.
module f2x_round_sat
  import f2x_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             sign,
  input  f2x_cls_e         cls,
  input  logic [WIDTH:0]   mag,
  input  logic             rnd,
  input  logic             huge,
  output logic [WIDTH-1:0] fixed,
  output logic [2:0]       flags
);
`ifdef F2X_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif
  localparam logic [WIDTH+1:0] LIM  = (WIDTH+2)'(1) << (WIDTH-1);
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH+1:0] rmag;

  always_comb begin
    fixed = '0;
    flags = '0;
    // Ties-away rounding only needs the first discarded bit.
    rmag  = {1'b0, mag} + {{(WIDTH+1){1'b0}}, rnd & ROUND_EN};
    case (cls)
      CLS_ZERO: ;
      CLS_NAN:  flags[FLAG_NAN] = 1'b1;
      CLS_INF: begin
        fixed           = sign ? MINN : MAXP;
        flags[FLAG_OVF] = 1'b1;
      end
      CLS_NORM: begin
        if (huge || (sign ? (rmag > LIM) : (rmag >= LIM))) begin
          fixed           = sign ? MINN : MAXP;
          flags[FLAG_OVF] = 1'b1;
        end else if (rmag == '0) begin
          flags[FLAG_UNF] = 1'b1;
        end else begin
          fixed = sign ? -rmag[WIDTH-1:0] : rmag[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/float_to_fixed_pipe.sv
// IEEE-754 single to signed fixed point, 3-stage valid/ready pipeline (latency 3),
// whole pipe stalls when output is held; rounding selected by F2X_ROUND_EN.
module float_to_fixed_pipe
  import f2x_pkg::*;
#(
  parameter int INT_BITS  = 1,
  parameter int FRAC_BITS = 22,
  parameter int WIDTH     = 1 + INT_BITS + FRAC_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_float,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_fixed,
  output logic [2:0]       out_flags
);
  localparam int LW = WIDTH + SIG_W;
  localparam logic signed [9:0] SH_OFF = 10'(FRAC_BITS - MAN_W - BIAS);
  localparam logic signed [9:0] SH_MAX = 10'(WIDTH);

  logic              s1_vld_q, s1_vld_d, s1_sign_q, s1_sign_d;
  f2x_cls_e          s1_cls_q, s1_cls_d;
  logic [SIG_W-1:0]  s1_sig_q, s1_sig_d;
  logic signed [9:0] s1_sh_q, s1_sh_d;
  logic              s2_vld_q, s2_vld_d, s2_sign_q, s2_sign_d;
  f2x_cls_e          s2_cls_q, s2_cls_d;
  logic [WIDTH:0]    s2_mag_q, s2_mag_d;
  logic              s2_rnd_q, s2_rnd_d, s2_huge_q, s2_huge_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_fixed_q, out_fixed_d;
  logic [2:0]        out_flags_q, out_flags_d;

  logic              adv;
  logic [EXP_W-1:0]  in_exp;
  logic [LW-1:0]     al_ext;
  logic [SIG_W:0]    al_rsh;
  logic [9:0]        al_nsh;
  logic [4:0]        al_amt;
  logic              al_clamp, al_rnd, al_huge;
  logic [WIDTH:0]    al_mag;
  logic [WIDTH-1:0]  rs_fixed;
  logic [2:0]        rs_flags;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign in_exp   = in_float[30:23];

  // Alignment: left shifts past WIDTH are certain overflow, right shifts past
  // the significand plus round bit leave nothing, so both counts clamp.
  always_comb begin
    al_ext   = '0;
    al_rsh   = '0;
    al_nsh   = '0;
    al_amt   = '0;
    al_clamp = 1'b0;
    al_rnd   = 1'b0;
    if (!s1_sh_q[9]) begin
      if (s1_sh_q > SH_MAX) al_clamp = 1'b1;
      else al_ext = LW'(s1_sig_q) << s1_sh_q[6:0];
    end else begin
      al_nsh = -s1_sh_q;
      al_amt = (al_nsh > 10'd25) ? 5'd25 : al_nsh[4:0];
      al_rsh = {s1_sig_q, 1'b0} >> al_amt;
      al_ext = LW'(al_rsh[SIG_W:1]);
      al_rnd = al_rsh[0];
    end
  end
  assign al_huge = al_clamp || (|al_ext[LW-1:WIDTH+1]);
  assign al_mag  = al_ext[WIDTH:0];

  f2x_round_sat #(.WIDTH(WIDTH)) u_round_sat (
    .sign  (s2_sign_q),
    .cls   (s2_cls_q),
    .mag   (s2_mag_q),
    .rnd   (s2_rnd_q),
    .huge  (s2_huge_q),
    .fixed (rs_fixed),
    .flags (rs_flags)
  );

  always_comb begin
    s1_vld_d = s1_vld_q;  s1_sign_d = s1_sign_q; s1_cls_d = s1_cls_q;
    s1_sig_d = s1_sig_q;  s1_sh_d = s1_sh_q;
    s2_vld_d = s2_vld_q;  s2_sign_d = s2_sign_q; s2_cls_d = s2_cls_q;
    s2_mag_d = s2_mag_q;  s2_rnd_d = s2_rnd_q;   s2_huge_d = s2_huge_q;
    out_valid_d = out_valid_q; out_fixed_d = out_fixed_q; out_flags_d = out_flags_q;
    if (adv) begin
      s1_vld_d  = in_valid;
      s1_sign_d = in_float[31];
      s1_sig_d  = {1'b1, in_float[MAN_W-1:0]};
      s1_sh_d   = $signed({2'b00, in_exp}) + SH_OFF;
      if (in_exp == '0)          s1_cls_d = CLS_ZERO;
      else if (in_exp != EXP_ONES) s1_cls_d = CLS_NORM;
      else if (in_float[MAN_W-1:0] != '0) s1_cls_d = CLS_NAN;
      else                       s1_cls_d = CLS_INF;
      s2_vld_d  = s1_vld_q;  s2_sign_d = s1_sign_q; s2_cls_d = s1_cls_q;
      s2_mag_d  = al_mag;    s2_rnd_d  = al_rnd;    s2_huge_d = al_huge;
      out_valid_d = s2_vld_q; out_fixed_d = rs_fixed; out_flags_d = rs_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0; s1_sign_q <= 1'b0; s1_cls_q <= CLS_ZERO;
      s1_sig_q <= '0;   s1_sh_q <= '0;
      s2_vld_q <= 1'b0; s2_sign_q <= 1'b0; s2_cls_q <= CLS_ZERO;
      s2_mag_q <= '0;   s2_rnd_q <= 1'b0;  s2_huge_q <= 1'b0;
      out_valid_q <= 1'b0; out_fixed_q <= '0; out_flags_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d; s1_sign_q <= s1_sign_d; s1_cls_q <= s1_cls_d;
      s1_sig_q <= s1_sig_d; s1_sh_q <= s1_sh_d;
      s2_vld_q <= s2_vld_d; s2_sign_q <= s2_sign_d; s2_cls_q <= s2_cls_d;
      s2_mag_q <= s2_mag_d; s2_rnd_q <= s2_rnd_d;   s2_huge_q <= s2_huge_d;
      out_valid_q <= out_valid_d; out_fixed_q <= out_fixed_d; out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_fixed = out_fixed_q;
  assign out_flags = out_flags_q;
endmodule

// File: doc/float_to_fixed_pipe.md
FLOAT_TO_FIXED_PIPE -- requirements
Module: float_to_fixed_pipe

Interface
REQ-001 Parameter INT_BITS, default 1, integer bits of fixed output; legal 1..30.
REQ-002 Parameter FRAC_BITS, default 22, fraction bits of fixed output; legal 0..32.
REQ-003 Parameter WIDTH, default 1+INT_BITS+FRAC_BITS, output width (sign+int+frac); SHALL not be overridden; WIDTH<=64.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  in_float holds a valid IEEE-754 single.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 in_float  in  32  IEEE-754 single {sign, exp[7:0], man[22:0]}.
REQ-009 out_valid  out  1  out_fixed/out_flags valid.
REQ-010 out_ready  in  1  sink accepts output this cycle.
REQ-011 out_fixed  out  WIDTH  two's-complement result, FRAC_BITS fractional bits.
REQ-012 out_flags  out  3  {nan, ovf, unf}, qualified by out_valid.

Function
REQ-013 Transfer occurs on a cycle with valid&ready high on the same port; no other cycle moves data.
REQ-014 Three register stages: S1 unpack/classify, S2 align shift, S3 round/negate/saturate; latency exactly 3 cycles from input handshake to out_valid when unstalled.
REQ-015 Pipeline advances when (!out_valid | out_ready); in_ready SHALL equal this term; on stall all stages hold; throughput 1/cycle when unstalled.
REQ-016 Pipeline order preserved; no transfer dropped or duplicated under any out_ready pattern.
REQ-017 Normal input: value = (-1)^s * 1.man * 2^(exp-127), scaled by 2^FRAC_BITS, aligned by left or right shift of the 24-bit significand by (exp-127+FRAC_BITS-23).
REQ-018 Zero (+/-) and denormals (exp=0) SHALL produce 0, flags 0.
REQ-019 NaN (exp=255, man!=0) SHALL produce 0, nan=1.
REQ-020 +Inf -> 2^(WIDTH-1)-1, -Inf -> -2^(WIDTH-1); ovf=1 in both.
REQ-021 Magnitude after rounding >= 2^(WIDTH-1) for positive, or > 2^(WIDTH-1) for negative, SHALL saturate as REQ-020 with ovf=1; negative magnitude exactly 2^(WIDTH-1) yields -2^(WIDTH-1), ovf=0.
REQ-022 Nonzero normal input with rounded result 0 SHALL set unf=1.
REQ-023 Negative results SHALL be two's-complement negation of the rounded magnitude; -0 never produced.
REQ-024 Shift amounts beyond significand width SHALL clamp (no wrap-around of shift count).

Reset
REQ-025 On reset, out_valid=0, all stage valid bits 0, out_fixed=0, out_flags=0 at the next edge.
REQ-026 Reset mid-operation discards all in-flight data; in_ready=1 in the cycle after reset deasserts.

Configuration
REQ-027 Macro F2X_ROUND_EN defined: round to nearest, ties away from zero, on the discarded bits.
REQ-028 F2X_ROUND_EN undefined: truncate magnitude toward zero; latency and interface unchanged.

Structure
REQ-029 Package f2x_pkg holds: IEEE field widths (1/8/23), bias 127, exp all-ones constant, flag bit indices (NAN=2, OVF=1, UNF=0).
REQ-030 Stage S3 implemented in one sub-module f2x_round_sat (round, negate, saturate, flags), combinational.

Verification (INT_BITS=1, FRAC_BITS=22, WIDTH=24, out_ready=1 unless stated)
REQ-031 0x3F800000 (1.0) -> 0x400000; 0xBF800000 (-1.0) -> 0xC00000; 0x3F000000 (0.5) -> 0x200000; flags 0; each 3 cycles after accept.
REQ-032 0x40000000 (2.0) -> 0x7FFFFF ovf=1; 0xC0000000 (-2.0) -> 0x800000 ovf=0; 0x7F800000 -> 0x7FFFFF ovf=1; 0x7FC00000 -> 0 nan=1.
REQ-033 0x34000000 (2^-23): with F2X_ROUND_EN -> 0x000001 unf=0; without -> 0x000000 unf=1; 0x00400000 (denormal) -> 0 flags 0.
REQ-034 Stream 8 values with in_valid=1, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 once 3 stages full, all 8 results in order, none lost/duplicated.
REQ-035 Assert reset for 1 cycle with 3 transfers in flight -> out_valid=0 next cycle, none of those results emitted, in_ready=1 after reset.
